bin_to_bcd_seq: RTL
===================

Name: bin_to_bcd_seq

Overview:
- Parametrised, multi-cycle binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock.
- Replaces the fixed 4-bit combinational converter. It is generalised to WIDTH-bit operands, with an optional two's-complement mode and valid/ready handshakes on both sides.
- Sits between the vedic multiplier product register and the seven-segment/LED display drivers.

Parameters:
- WIDTH, 8, binary input width; legal range 4..32.
- SIGNED, 0, 1 = input is two's complement; magnitude is converted and the sign is reported on out_neg.
- DIGITS, (WIDTH*301)/1000+1, BCD digit count; derived localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_bin holds a valid operand.
- in_ready  out  1  converter can accept an operand.
- in_bin  in  WIDTH  binary operand.
- out_valid  out  1  out_bcd/out_neg hold a valid result.
- out_ready  in  1  downstream accepts the result.
- out_bcd  out  4*DIGITS  packed BCD; digit 0 (units) in bits [3:0].
- out_neg  out  1  operand was negative (SIGNED=1 only; otherwise tied 0).

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; in_ready=1; out_valid=0; out_bcd=0; out_neg=0; bit counter=0.
  - Reset wins over every other event, including mid-conversion or while out_valid=1. The in-flight result is discarded.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1, load the shift register with the operand and clear the BCD accumulator. Counter=0; go to SHIFT.
  - SIGNED=1 with in_bin[WIDTH-1]=1: load -in_bin (WIDTH-bit magnitude) and latch neg=1. Otherwise neg=0.
  - Most negative value 2^(WIDTH-1) converts correctly as an unsigned magnitude.
- SHIFT:
  - in_ready=0.
  - Each cycle, add 3 to every BCD digit that is >=5, then shift {bcd, bin} left by 1. Counter increments.
  - After the WIDTH-th shift, go to DONE. out_bcd and out_neg update on that same edge.
- DONE:
  - out_valid=1; out_bcd and out_neg held stable while out_ready=0 (unlimited backpressure).
  - On out_ready=1, go to IDLE; out_valid=0 next cycle. out_bcd keeps its last value (not cleared).
- Latency: accept at edge E0 gives out_valid=1 after edge E(WIDTH). Minimum spacing between accepts is WIDTH+2 cycles.
- No accept in the DONE cycle (in_ready=0 there). in_valid outside IDLE is ignored, and the operand is not captured.
- out_valid never deasserts without out_ready=1 or rst=1.
- Unused upper bits of the top digit are always 0. A digit value >9 is a design error; the bench asserts against it.
- Counter width is clog2(WIDTH+1); it never wraps within a conversion.

Decomposition:
- Shared package bcd_pkg holds:
  - state enum {IDLE, SHIFT, DONE};
  - function bcd_digits(width) returning (width*301)/1000+1;
  - constant BCD_NIBBLE=4.
- One sub-module, bcd_add3_digit: a combinational 4-bit in/out block giving out = (in>=5) ? in+3 : in. It is instantiated DIGITS times via generate.

Test Plan:
- WIDTH=8, SIGNED=0: in_bin=8'd255, out_ready=1 -> out_valid rises 8 cycles after accept; out_bcd=12'h255, out_neg=0.
- WIDTH=8: in_bin=0 then in_bin=8'd99 back-to-back with in_valid held -> results 12'h000 then 12'h099. The second accept occurs exactly WIDTH+2 cycles after the first.
- WIDTH=8, SIGNED=1: in_bin=8'h80 -> out_bcd=12'h128, out_neg=1. in_bin=8'hF9 -> 12'h007, out_neg=1.
- Backpressure: out_ready=0 for 20 cycles after result 12'h137 (in_bin=137) -> out_valid, out_bcd stable; in_ready=0 throughout; operand change ignored.
- Reset mid-conversion: rst=1 at shift 4 of in_bin=200 -> next cycle in_ready=1, out_valid=0, out_bcd=0. New operand 42 -> 12'h042.
- WIDTH=16, DIGITS=5: in_bin=16'hFFFF -> out_bcd=20'h65535 after 16 cycles. Randomised sweep vs reference model across WIDTH=4, 8, 16, 32 with no mismatches.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int BCD_NIBBLE = 4;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    // Decimal digits needed for a width-bit unsigned value (log10(2) ~ 0.301).
    function automatic int bcd_digits(input int width);
        return (width * 301) / 1000 + 1;
    endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added before the shift.
module bcd_add3_digit
    import bcd_pkg::*;
(
    input  logic [BCD_NIBBLE-1:0] digit,
    output logic [BCD_NIBBLE-1:0] adjusted
);

    always_comb begin
        adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Multi-cycle binary-to-BCD converter (shift-and-add-3, one bit per clock)
// with valid/ready handshakes and optional two's-complement input.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0,
    localparam int DIGITS = bcd_digits(WIDTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_bin,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BCD_NIBBLE*DIGITS-1:0] out_bcd,
    output logic                       out_neg
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int BCD_W = BCD_NIBBLE * DIGITS;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t state, state_next;

    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] bin_sr;
    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] operand;
    logic [BCD_W-1:0] bcd_acc;
    logic [BCD_W-1:0] bcd_adj;
    logic [BCD_W-1:0] bcd_shifted;
    logic             neg;
    logic             operand_neg;
    logic             load;
    logic             step;
    logic             unused_carry;

    // Only the magnitude is converted; the sign travels separately.
    assign operand_neg = SIGNED && in_bin[WIDTH-1];
    assign operand     = operand_neg ? -in_bin : in_bin;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (count == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
        bcd_add3_digit u_add3 (
            .digit    (bcd_acc[d*BCD_NIBBLE +: BCD_NIBBLE]),
            .adjusted (bcd_adj[d*BCD_NIBBLE +: BCD_NIBBLE])
        );
    end

    // The top digit never reaches 8 for an in-range operand, so its MSB carries nothing.
    assign unused_carry = bcd_adj[BCD_W-1];
    assign bcd_shifted  = {bcd_adj[BCD_W-2:0], bin_sr[WIDTH-1]};
    assign bin_next     = {bin_sr[WIDTH-2:0], 1'b0};

    always_ff @(posedge clk) begin
        if (load) begin
            bin_sr  <= operand;
            bcd_acc <= '0;
            neg     <= operand_neg;
        end else if (step) begin
            bin_sr  <= bin_next;
            bcd_acc <= bcd_shifted;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            out_bcd <= '0;
            out_neg <= 1'b0;
        end else if (load) begin
            count <= '0;
        end else if (step) begin
            count <= count + 1'b1;
            if (count == LAST) begin
                out_bcd <= bcd_shifted;
                out_neg <= neg;
            end
        end
    end

endmodule
